// File: rtl/rf_pkg.sv
// Shared register-file write-side types and constants used by the write arbiter
// and its per-source write queues.
package rf_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0]  REG_ZERO = 5'd0;
    localparam logic [DATA_W-1:0] SP_RESET = 32'h100;

    typedef struct packed {
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;

    // Which source drives the regfile write port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MDU  = 2'd2,
        GNT_MEM  = 2'd3
    } grant_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] wa);
        logic [NUM_REGS-1:0] v;
        v     = '0;
        v[wa] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_wb_fifo.sv
// Small circular buffer of pending register writes; exposes per-entry valid bits
// and destination registers so the owner can build a pending-write mask.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  wb_req_t                      i_push_data,
    input  logic                         i_pop,
    output wb_req_t                      o_pop_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [DEPTH-1:0]             o_valid,
    output logic [DEPTH-1:0][REG_W-1:0]  o_entry_wa
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t [DEPTH-1:0] r_mem;
    logic    [DEPTH-1:0] r_valid;
    logic    [PTR_W-1:0] r_wr_ptr;
    logic    [PTR_W-1:0] r_rd_ptr;

    // Occupancy is carried by the valid bits; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '0;
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_pop && !o_empty) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (i_push && !o_full) begin
                r_mem[r_wr_ptr]   <= i_push_data;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
        end
    end

    assign o_full     = &r_valid;
    assign o_empty    = ~|r_valid;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_valid    = r_valid;

    always_comb begin
        o_entry_wa = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_wa[i] = r_mem[i].wa;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port initiator for the 3R/1W register file: pipeline writeback has
// priority, MDU and load returns are queued and served round-robin with starvation relief.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_we,
    input  logic [REG_W-1:0]    pipe_wa,
    input  logic [DATA_W-1:0]   pipe_wd,
    output logic                pipe_stall,
    input  logic                mdu_valid,
    output logic                mdu_ready,
    input  logic [REG_W-1:0]    mdu_wa,
    input  logic [DATA_W-1:0]   mdu_wd,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_W-1:0]    mem_wa,
    input  logic [DATA_W-1:0]   mem_wd,
    output logic                rf_we,
    output logic [REG_W-1:0]    rf_wa,
    output logic [DATA_W-1:0]   rf_wd,
    output logic [NUM_REGS-1:0] pend_mask
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic                         r_rf_we;
    logic [REG_W-1:0]             r_rf_wa;
    logic [DATA_W-1:0]            r_rf_wd;
    logic [CNT_W-1:0]             r_starve;
    logic                         r_last_mem;

    logic                         w_mdu_push, w_mem_push;
    logic                         w_mdu_pop, w_mem_pop;
    logic                         w_mdu_full, w_mem_full;
    logic                         w_mdu_empty, w_mem_empty;
    wb_req_t                      w_mdu_head, w_mem_head;
    logic [DEPTH-1:0]             w_mdu_valid, w_mem_valid;
    logic [DEPTH-1:0][REG_W-1:0]  w_mdu_wa, w_mem_wa;
    logic                         w_any_q;
    logic                         w_stall;
    grant_e                       w_rr;
    grant_e                       w_grant;
    logic [NUM_REGS-1:0]          w_pend;

    assign mdu_ready  = !rst && !w_mdu_full;
    assign mem_ready  = !rst && !w_mem_full;
    // Writes to r0 complete the handshake but are never stored.
    assign w_mdu_push = mdu_valid && mdu_ready && (mdu_wa != REG_ZERO);
    assign w_mem_push = mem_valid && mem_ready && (mem_wa != REG_ZERO);

    wb_fifo #(.DEPTH(DEPTH)) u_mdu_q (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_mdu_push),
        .i_push_data('{wa: mdu_wa, wd: mdu_wd}),
        .i_pop      (w_mdu_pop),
        .o_pop_data (w_mdu_head),
        .o_full     (w_mdu_full),
        .o_empty    (w_mdu_empty),
        .o_valid    (w_mdu_valid),
        .o_entry_wa (w_mdu_wa)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_q (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_mem_push),
        .i_push_data('{wa: mem_wa, wd: mem_wd}),
        .i_pop      (w_mem_pop),
        .o_pop_data (w_mem_head),
        .o_full     (w_mem_full),
        .o_empty    (w_mem_empty),
        .o_valid    (w_mem_valid),
        .o_entry_wa (w_mem_wa)
    );

    assign w_any_q = !w_mdu_empty || !w_mem_empty;
    assign w_stall = (r_starve == STARVE_LIM) && w_any_q;

    // On a tie the queue that was not granted last wins.
    always_comb begin
        w_rr = GNT_NONE;
        if (!w_mdu_empty && !w_mem_empty) begin
            w_rr = r_last_mem ? GNT_MDU : GNT_MEM;
        end else if (!w_mdu_empty) begin
            w_rr = GNT_MDU;
        end else if (!w_mem_empty) begin
            w_rr = GNT_MEM;
        end
    end

    // A pipeline write to r0 still owns its cycle, so no queue is served then.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_stall) begin
            w_grant = w_rr;
        end else if (pipe_we && (pipe_wa != REG_ZERO)) begin
            w_grant = GNT_PIPE;
        end else if (pipe_we) begin
            w_grant = GNT_NONE;
        end else begin
            w_grant = w_rr;
        end
    end

    assign w_mdu_pop = (w_grant == GNT_MDU);
    assign w_mem_pop = (w_grant == GNT_MEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_wa    <= '0;
            r_rf_wd    <= '0;
            r_starve   <= '0;
            r_last_mem <= 1'b1;
        end else begin
            case (w_grant)
                GNT_PIPE: begin
                    r_rf_we <= 1'b1;
                    r_rf_wa <= pipe_wa;
                    r_rf_wd <= pipe_wd;
                end
                GNT_MDU: begin
                    r_rf_we    <= 1'b1;
                    r_rf_wa    <= w_mdu_head.wa;
                    r_rf_wd    <= w_mdu_head.wd;
                    r_last_mem <= 1'b0;
                end
                GNT_MEM: begin
                    r_rf_we    <= 1'b1;
                    r_rf_wa    <= w_mem_head.wa;
                    r_rf_wd    <= w_mem_head.wd;
                    r_last_mem <= 1'b1;
                end
                default: begin
                    r_rf_we <= 1'b0;
                end
            endcase

            if (w_mdu_pop || w_mem_pop || !w_any_q) begin
                r_starve <= '0;
            end else if ((w_grant == GNT_PIPE) && (r_starve != STARVE_LIM)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // A popped entry drops out of the mask on the same edge rf_we starts presenting it.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_mdu_valid[i]) w_pend = w_pend | reg_onehot(w_mdu_wa[i]);
            if (w_mem_valid[i]) w_pend = w_pend | reg_onehot(w_mem_wa[i]);
        end
        w_pend[0] = 1'b0;
    end

    assign pend_mask  = w_pend;
    assign pipe_stall = w_stall;
    assign rf_we      = r_rf_we;
    assign rf_wa      = r_rf_wa;
    assign rf_wd      = r_rf_wd;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized checks of rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        pipe_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_wd;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_we   (pipe_we),
        .pipe_wa   (pipe_wa),
        .pipe_wd   (pipe_wd),
        .pipe_stall(pipe_stall),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_wa    (mdu_wa),
        .mdu_wd    (mdu_wd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: each queue holds {wa, wd} in arrival order.
    logic [36:0] mdu_q[$];
    logic [36:0] mem_q[$];
    int          m_starve;
    bit          m_last_mem;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = '0;
        foreach (mdu_q[i]) m[mdu_q[i][36:32]] = 1'b1;
        foreach (mem_q[i]) m[mem_q[i][36:32]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        mdu_q.delete();
        mem_q.delete();
        m_starve   = 0;
        m_last_mem = 1'b1;
        m_we       = 1'b0;
        m_wa       = '0;
        m_wd       = '0;
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic dv, input logic [4:0] dwa, input logic [31:0] dwd,
                         input logic ev, input logic [4:0] ewa, input logic [31:0] ewd);
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
        mdu_valid = dv; mdu_wa = dwa; mdu_wd = dwd;
        mem_valid = ev; mem_wa = ewa; mem_wd = ewd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check state-derived outputs before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        bit any, stall, mdu_acc, mem_acc;
        int g;
        logic [36:0] e;
        #3;
        any   = (mdu_q.size() > 0) || (mem_q.size() > 0);
        stall = (m_starve == STARVE_MAX) && any;
        chk("mdu_ready", 32'(mdu_ready), 32'(!rst && mdu_q.size() < DEPTH));
        chk("mem_ready", 32'(mem_ready), 32'(!rst && mem_q.size() < DEPTH));
        chk("pipe_stall", 32'(pipe_stall), 32'(stall));
        chk("pend_mask", pend_mask, model_pend());
        mdu_acc = !rst && mdu_valid && (mdu_q.size() < DEPTH);
        mem_acc = !rst && mem_valid && (mem_q.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            g = 0;
            if (stall || !pipe_we) begin
                if (mdu_q.size() > 0 && mem_q.size() > 0) g = m_last_mem ? 2 : 3;
                else if (mdu_q.size() > 0) g = 2;
                else if (mem_q.size() > 0) g = 3;
            end else if (pipe_wa != 0) begin
                g = 1;
            end
            m_we = (g != 0);
            if (g == 1) begin
                m_wa = pipe_wa; m_wd = pipe_wd;
            end else if (g == 2) begin
                e = mdu_q.pop_front(); m_wa = e[36:32]; m_wd = e[31:0]; m_last_mem = 1'b0;
            end else if (g == 3) begin
                e = mem_q.pop_front(); m_wa = e[36:32]; m_wd = e[31:0]; m_last_mem = 1'b1;
            end
            if (g >= 2 || !any) m_starve = 0;
            else if (g == 1) m_starve++;
            if (mdu_acc && mdu_wa != 0) mdu_q.push_back({mdu_wa, mdu_wd});
            if (mem_acc && mem_wa != 0) mem_q.push_back({mem_wa, mem_wd});
        end
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("rf_wa", 32'(rf_wa), 32'(m_wa));
        chk("rf_wd", rf_wd, m_wd);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_rf_wa", 32'(rf_wa), 32'd0);
        chk("reset_rf_wd", rf_wd, 32'd0);
        chk("reset_pend", pend_mask, 32'd0);
        chk("reset_stall", 32'(pipe_stall), 32'd0);
        chk("reset_mdu_ready", 32'(mdu_ready), 32'd1);
        chk("reset_mem_ready", 32'(mem_ready), 32'd1);

        // Pipeline write appears one edge later, then holds while idle.
        drive(1, 5'd8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("pipe_we", 32'(rf_we), 32'd1);
        chk("pipe_wa", 32'(rf_wa), 32'd8);
        chk("pipe_wd", rf_wd, 32'hDEADBEEF);
        idle();
        cycle();
        chk("idle_we", 32'(rf_we), 32'd0);
        chk("idle_hold_wd", rf_wd, 32'hDEADBEEF);

        // Both queues filled at once: MDU first, then load.
        drive(0, 0, 0, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2);
        cycle();
        chk("cont_pend0", pend_mask, 32'h18);
        chk("cont_we0", 32'(rf_we), 32'd0);
        idle();
        cycle();
        chk("cont_wa1", 32'(rf_wa), 32'd3);
        chk("cont_pend1", pend_mask, 32'h10);
        cycle();
        chk("cont_wa2", 32'(rf_wa), 32'd4);
        chk("cont_wd2", rf_wd, 32'd2);
        chk("cont_pend2", pend_mask, 32'h0);

        // Load queue fills while pipeline keeps winning, until starvation relief.
        drive(1, 5'd9, 32'h99, 0, 0, 0, 1, 5'd5, 32'h55);
        cycle();
        cycle();
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        cycle();
        cycle();
        chk("starve_not_yet", 32'(pipe_stall), 32'd0);
        cycle();
        chk("starve_stall", 32'(pipe_stall), 32'd1);
        cycle();
        chk("starve_wa", 32'(rf_wa), 32'd5);
        chk("starve_wd", rf_wd, 32'h55);
        chk("starve_drop", 32'(pipe_stall), 32'd0);
        cycle();
        chk("held_pipe_wa", 32'(rf_wa), 32'd9);
        chk("held_pipe_we", 32'(rf_we), 32'd1);
        idle();
        repeat (3) cycle();
        chk("drain_pend", pend_mask, 32'h0);

        // Zero-register write is accepted but never stored or written.
        drive(0, 0, 0, 1, 5'd0, 32'h77, 0, 0, 0);
        cycle();
        chk("zero_pend", pend_mask, 32'h0);
        idle();
        cycle();
        chk("zero_we", 32'(rf_we), 32'd0);

        // Reset with two queued entries discards them.
        drive(0, 0, 0, 1, 5'd6, 32'h66, 1, 5'd7, 32'h77);
        cycle();
        chk("mid_pend", pend_mask, 32'hC0);
        idle();
        rst = 1'b1;
        cycle();
        chk("mid_rst_pend", pend_mask, 32'h0);
        rst = 1'b0;
        cycle();
        chk("mid_rst_we0", 32'(rf_we), 32'd0);
        cycle();
        chk("mid_rst_we1", 32'(rf_we), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 7) == 0) begin
                mdu_wa = 5'd0;
            end
            cycle();
        end
        rst = 1'b0;
        idle();
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Write-side initiator for the 3-read/1-write register file.
- Merges three write sources into the single write port (we/wa/wd):
  - main pipeline writeback (always accepted, priority)
  - multiply/divide unit (valid/ready)
  - load-return path (valid/ready)
- Buffers the secondary sources and exports a pending-write mask for hazard stalling.

Parameters:
DEPTH, 2, entries per secondary queue (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles a non-empty queue may be bypassed by the pipeline before pipe_stall asserts

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
pipe_we  in  1  pipeline writeback request
pipe_wa  in  5  pipeline dest register
pipe_wd  in  32  pipeline data
pipe_stall  out  1  pipeline must hold its writeback this cycle; pipe_we ignored
mdu_valid  in  1  MDU write request
mdu_ready  out  1  MDU queue can accept
mdu_wa  in  5  MDU dest
mdu_wd  in  32  MDU data
mem_valid  in  1  load-return request
mem_ready  out  1  load queue can accept
mem_wa  in  5  load dest
mem_wd  in  32  load data
rf_we  out  1  to regfile we
rf_wa  out  5  to regfile wa
rf_wd  out  32  to regfile wd
pend_mask  out  32  bit r set = register r has a queued, unwritten value

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - rst is synchronous and active-high, sampled on rising edge.
  - Reset clears both queues, starve counter and grant pointer; buffered writes are discarded.
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, pend_mask=0, pipe_stall=0.
- Ready outputs:
  - mdu_ready/mem_ready = !rst && queue not full.
  - Evaluated from current occupancy; a full queue does not accept even when dequeuing the same cycle.
- Enqueue:
  - Occurs on a rising edge with valid && ready.
  - Requests with wa==0 complete the handshake but are dropped (not stored).
- Output stage:
  - rf_we/rf_wa/rf_wd are registered; the regfile commits them on the following falling edge.
  - Pipeline latency: pipe_we at edge N -> rf_we=1 after edge N.
  - Queue latency: enqueue at edge N -> earliest rf_we after edge N+1 (no bypass).
- Grant per cycle, in priority order:
  1. pipe_stall=1 -> serve a queue per round-robin.
  2. Else pipe_we=1 and pipe_wa!=0 -> pipeline wins.
  3. Else pipe_we=1 and pipe_wa==0 -> consumes the cycle, rf_we=0, no queue served.
  4. Else round-robin between non-empty queues.
  5. Else rf_we=0; rf_wa/rf_wd hold their previous values.
- Round-robin:
  - A one-bit last-grant pointer; on a tie, grant the queue not granted last.
  - Pointer resets to "mem", so MDU wins the first tie.
- Starvation:
  - Counter increments each cycle in which a queue is non-empty and the pipeline is granted.
  - Clears on any queue grant or when both queues are empty.
  - pipe_stall = (counter == STARVE_MAX) && any queue non-empty; it is combinational from registered state.
  - The pipeline must hold pipe_we/wa/wd until pipe_stall drops.
- pend_mask:
  - OR of one-hot(wa) over all valid entries of both queues; combinational from queue state.
  - Bit 0 is always 0.
  - An entry's bit clears in the cycle after it is granted, i.e. when rf_we presents it.
- Ordering:
  - FIFO order within each queue.
  - No ordering across sources; same-register WAW is prevented by the pipeline stalling on pend_mask.
- Simultaneous enqueue and dequeue on the same queue is allowed when not full; occupancy is unchanged.

Decomposition:
- Package rf_pkg holds:
  - REG_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0, SP_RESET=32'h100
  - typedef wb_req_t {wa[4:0], wd[31:0]}
- Sub-module wb_fifo (parameter DEPTH), instantiated twice. It provides:
  - synchronous-reset circular buffer of wb_req_t
  - push/pop, full/empty
  - per-entry valid vector, for pend_mask generation

Test Plan:
- Reset with rst=1 for 2 cycles, then release -> rf_we=0, pend_mask=0, mdu_ready=mem_ready=1.
- Pipeline write: pipe_we=1, wa=8, wd=32'hDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_wa=8, rf_wd=32'hDEADBEEF; regfile rd of r8 returns it.
- Contention:
  - Stimulus, same cycle: mdu (wa=3, wd=1), mem (wa=4, wd=2), pipe idle.
  - Response: rf writes r3 in the next cycle, then r4 in the following cycle.
  - pend_mask goes 0x18 -> 0x10 -> 0x0.
- Queue full: hold mem_valid=1 (wa=5) with pipe_we=1 continuously -> mem_ready=0 after DEPTH=2 accepts.
- Starvation, continuing from the queue-full scenario:
  - After 4 consecutive pipeline grants, pipe_stall=1 for one cycle.
  - The mem entry for r5 is written.
  - pipe_stall then drops and the held pipe write follows next.
- Zero register and reset mid-operation:
  - mdu write with wa=0 -> handshake completes, rf_we never asserts, pend_mask bit0 stays 0.
  - rst asserted with 2 queued entries -> both discarded, pend_mask=0, no rf_we afterwards.
